// File: rtl/mem_access_stage.sv
// M-stage memory access unit: aligns loads/stores onto a req/ack data bus, stalls until completion,
// and holds the M/W register. Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  input  logic        m_load,
  input  logic        m_store,
  input  logic [2:0]  m_ldst_type,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        w_valid,
  output logic [31:0] w_addr,
  output logic [2:0]  w_ldst_type,
  output logic [31:0] w_rdata,
  output logic [1:0]  w_exc
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;

  logic        op, isStore, isByte, isHalf, misaligned;
  logic        issue, complete, timeout;
  logic [3:0]  beD;
  logic [31:0] wdataD;
  logic [1:0]  excD;

  logic        memReq_q, memWe_q;
  logic [3:0]  memBe_q;
  logic [31:0] memAddr_q, memWdata_q;

  logic        wValid_q;
  logic [31:0] wAddr_q, wRdata_q;
  logic [2:0]  wLdstType_q;
  logic [1:0]  wExc_q;

  // A combined load+store request behaves as a store; unknown type codes are treated as words.
  assign op      = m_valid & (m_load | m_store);
  assign isStore = m_store;
  assign isByte  = (m_ldst_type == 3'b001) || (m_ldst_type == 3'b010);
  assign isHalf  = (m_ldst_type == 3'b011) || (m_ldst_type == 3'b100);

  always_comb begin
    misaligned = 1'b0;
    if (isHalf) begin
      misaligned = m_addr[0];
    end else if (!isByte) begin
      misaligned = (m_addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    beD    = 4'b1111;
    wdataD = m_wdata;
    if (isStore) begin
      if (isByte) begin
        beD    = 4'b0001 << m_addr[1:0];
        wdataD = {4{m_wdata[7:0]}};
      end else if (isHalf) begin
        beD    = m_addr[1] ? 4'b1100 : 4'b0011;
        wdataD = {2{m_wdata[15:0]}};
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;

  always_comb begin
    timeoutCnt_d = timeoutCnt_q;
    if (issue) begin
      timeoutCnt_d = '0;
    end else if ((state_q == BUSY) && !mem_ack) begin
      timeoutCnt_d = timeoutCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutCnt_q <= '0;
    end else begin
      timeoutCnt_q <= timeoutCnt_d;
    end
  end

  assign timeout = (state_q == BUSY) && !mem_ack &&
                   (timeoutCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unusedTimeoutCfg;

  assign unusedTimeoutCfg = (TIMEOUT_CYCLES == 0);
  assign timeout          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op && !misaligned) state_d = BUSY;
      BUSY:    if (mem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue    = 1'b0;
    complete = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        issue = op && !misaligned;
        stall = issue;
      end
      BUSY: begin
        complete = mem_ack;
        stall    = !mem_ack && !timeout;
      end
      default: ;
    endcase
  end

  // Bus fields are captured once at issue and held until the access ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memBe_q     <= 4'b0000;
      memAddr_q   <= 32'h0;
      memWdata_q  <= 32'h0;
    end else if (issue) begin
      memReq_q    <= 1'b1;
      memWe_q     <= isStore;
      memBe_q     <= beD;
      memAddr_q   <= {m_addr[31:2], 2'b00};
      memWdata_q  <= wdataD;
    end else if (complete || timeout) begin
      memReq_q    <= 1'b0;
    end
  end

  always_comb begin
    excD = 2'b00;
    if (timeout) begin
      excD = 2'b11;
    end else if ((state_q == IDLE) && op && misaligned) begin
      excD = isStore ? 2'b10 : 2'b01;
    end
  end

  // M/W register: a stall inserts a bubble and keeps the remaining fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wValid_q    <= 1'b0;
      wAddr_q     <= 32'h0;
      wLdstType_q <= 3'b000;
      wRdata_q    <= 32'h0;
      wExc_q      <= 2'b00;
    end else if (stall) begin
      wValid_q    <= 1'b0;
    end else begin
      wValid_q    <= m_valid;
      wAddr_q     <= m_addr;
      wLdstType_q <= m_ldst_type;
      wRdata_q    <= (complete && !memWe_q) ? mem_rdata : 32'h0;
      wExc_q      <= excD;
    end
  end

  assign mem_req     = memReq_q;
  assign mem_we      = memWe_q;
  assign mem_be      = memBe_q;
  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign w_valid     = wValid_q;
  assign w_addr      = wAddr_q;
  assign w_ldst_type = wLdstType_q;
  assign w_rdata     = wRdata_q;
  assign w_exc       = wExc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: W-stage results are scoreboarded in a queue and
// checked when w_valid appears; bus and stall behaviour are checked cycle by cycle.
module tb_mem_access_stage;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid, m_load, m_store;
  logic [2:0]  m_ldst_type;
  logic [31:0] m_addr, m_wdata;
  logic        stall, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        w_valid;
  logic [31:0] w_addr, w_rdata;
  logic [2:0]  w_ldst_type;
  logic [1:0]  w_exc;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  ldstType;
    logic [31:0] rdata;
    logic [1:0]  exc;
  } wExp_t;

  wExp_t expQ[$];
  int    checks   = 0;
  int    failures = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_load(m_load), .m_store(m_store),
    .m_ldst_type(m_ldst_type), .m_addr(m_addr), .m_wdata(m_wdata),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .w_valid(w_valid), .w_addr(w_addr), .w_ldst_type(w_ldst_type),
    .w_rdata(w_rdata), .w_exc(w_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic ld, input logic st, input logic [2:0] typ,
                               input logic [31:0] addr, input logic [31:0] wd);
    m_valid     = v;
    m_load      = ld;
    m_store     = st;
    m_ldst_type = typ;
    m_addr      = addr;
    m_wdata     = wd;
    #1;
  endtask

  task automatic pushExp(input logic [31:0] addr, input logic [2:0] typ,
                         input logic [31:0] rd, input logic [1:0] exc);
    wExp_t e;
    e.addr     = addr;
    e.ldstType = typ;
    e.rdata    = rd;
    e.exc      = exc;
    expQ.push_back(e);
  endtask

  // Advance one edge, then score any W-stage result that appeared.
  task automatic tick();
    wExp_t e;
    @(posedge clk);
    #1;
    if (w_valid === 1'b1) begin
      checkOutput("w_unexpected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("w_addr", w_addr, e.addr);
        checkOutput("w_ldst_type", 32'(w_ldst_type), 32'(e.ldstType));
        checkOutput("w_rdata", w_rdata, e.rdata);
        checkOutput("w_exc", 32'(w_exc), 32'(e.exc));
      end
    end
  endtask

  task automatic doAccess(input string tag, input logic ld, input logic st, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] wd, input int ackDelay,
                          input logic [31:0] rd, input logic [3:0] expBe, input logic [31:0] expWdata);
    applyStimulus(1'b1, ld, st, typ, addr, wd);
    checkOutput({tag, "_stall_issue"}, 32'(stall), 32'd1);
    pushExp(addr, typ, st ? 32'h0 : rd, 2'b00);
    tick();
    for (int k = 0; k <= ackDelay; k++) begin
      checkOutput({tag, "_req"}, 32'(mem_req), 32'd1);
      checkOutput({tag, "_we"}, 32'(mem_we), 32'(st));
      checkOutput({tag, "_be"}, 32'(mem_be), 32'(expBe));
      checkOutput({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
      if (st) checkOutput({tag, "_wdata"}, mem_wdata, expWdata);
      checkOutput({tag, "_bubble"}, 32'(w_valid), 32'd0);
      if (k < ackDelay) begin
        checkOutput({tag, "_stall_wait"}, 32'(stall), 32'd1);
        tick();
      end
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    #1;
    checkOutput({tag, "_stall_ack"}, 32'(stall), 32'd0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    checkOutput({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_wvalid"}, 32'(w_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic doMisaligned(input string tag, input logic ld, input logic st, input logic [2:0] typ,
                              input logic [31:0] addr, input logic [1:0] expExc);
    applyStimulus(1'b1, ld, st, typ, addr, 32'hFFFF_FFFF);
    checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
    pushExp(addr, typ, 32'h0, expExc);
    tick();
    checkOutput({tag, "_no_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_wvalid"}, 32'(w_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #12;
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_be", 32'(mem_be), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_wvalid", 32'(w_valid), 32'd0);
    checkOutput("rst_waddr", w_addr, 32'h0);
    checkOutput("rst_wtype", 32'(w_ldst_type), 32'd0);
    checkOutput("rst_wrdata", w_rdata, 32'h0);
    checkOutput("rst_wexc", 32'(w_exc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    doAccess("lw", 1, 0, 3'b000, 32'h1000_0004, 32'h0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    doAccess("sb", 0, 1, 3'b001, 32'h0000_0013, 32'h0000_00A5, 0, 32'h0, 4'b1000, 32'hA5A5_A5A5);
    doAccess("sh_hi", 0, 1, 3'b011, 32'h0000_0012, 32'h0000_1234, 0, 32'h0, 4'b1100, 32'h1234_1234);
    doAccess("sh_lo", 0, 1, 3'b100, 32'h0000_0010, 32'hABCD_5678, 0, 32'h0, 4'b0011, 32'h5678_5678);
    doAccess("sb_l0", 0, 1, 3'b010, 32'h0000_0020, 32'h0000_007E, 0, 32'h0, 4'b0001, 32'h7E7E_7E7E);
    doAccess("lb", 1, 0, 3'b010, 32'h0000_0021, 32'h0, 0, 32'h1122_3344, 4'b1111, 32'h0);
    doAccess("lbu_odd", 1, 0, 3'b001, 32'h0000_0003, 32'h0, 0, 32'h5566_7788, 4'b1111, 32'h0);

    doMisaligned("lh_mis", 1, 0, 3'b100, 32'h0000_0003, 2'b01);
    doMisaligned("sw_mis", 0, 1, 3'b000, 32'h0000_0002, 2'b10);
    doMisaligned("lw_mis", 1, 0, 3'b000, 32'h0000_0001, 2'b01);
    doMisaligned("ldst_mis", 1, 1, 3'b000, 32'h0000_0002, 2'b10);

    doAccess("lw_slow", 1, 0, 3'b000, 32'h2000_0008, 32'h0, 5, 32'hCAFE_F00D, 4'b1111, 32'h0);

    // Non-memory instruction passes straight through.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'h0);
    checkOutput("nop_stall", 32'(stall), 32'd0);
    pushExp(32'h0000_0077, 3'b000, 32'h0, 2'b00);
    tick();
    checkOutput("nop_wvalid", 32'(w_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    mem_ack = 1'b1;
    #1;
    checkOutput("idle_ack_stall", 32'(stall), 32'd0);
    tick();
    mem_ack = 1'b0;
    checkOutput("idle_ack_req", 32'(mem_req), 32'd0);
    checkOutput("idle_ack_wvalid", 32'(w_valid), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 32'h3000_0000, 32'h0);
    tick();
    tick();
    checkOutput("midrst_busy", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", 32'(mem_req), 32'd0);
    checkOutput("midrst_wvalid", 32'(w_valid), 32'd0);
    checkOutput("midrst_waddr", w_addr, 32'h0);
    checkOutput("midrst_wrdata", w_rdata, 32'h0);
    checkOutput("midrst_wexc", 32'(w_exc), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("midrst_stall", 32'(stall), 32'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    doAccess("sw_after_rst", 0, 1, 3'b000, 32'h0000_0040, 32'h8765_4321, 0, 32'h0, 4'b1111, 32'h8765_4321);

`ifdef MEM_TIMEOUT_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0050, 32'h0);
    pushExp(32'h0000_0050, 3'b000, 32'h0, 2'b11);
    tick();
    for (int k = 1; k < int'(TB_TIMEOUT); k++) begin
      checkOutput("to_req", 32'(mem_req), 32'd1);
      checkOutput("to_stall", 32'(stall), 32'd1);
      tick();
    end
    checkOutput("to_req_last", 32'(mem_req), 32'd1);
    checkOutput("to_stall_last", 32'(stall), 32'd0);
    tick();
    checkOutput("to_req_drop", 32'(mem_req), 32'd0);
    checkOutput("to_wvalid", 32'(w_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    doAccess("lw_after_to", 1, 0, 3'b000, 32'h0000_0060, 32'h0, 0, 32'h0BAD_F00D, 4'b1111, 32'h0);
`endif

    tick();
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- M-stage memory access unit of the MIPS pipeline.
- Accepts the M-stage load/store request and aligns store data into byte enables. Drives a req/ack data-memory bus and stalls the pipeline until the access completes.
- Holds the M/W pipeline register: word-aligned raw read word, full address and LdStType for the W-stage load data extender.
- Detects misaligned accesses; a misaligned access never reaches the bus.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUSY without mem_ack before a bus error (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  1  M-stage instruction valid
- m_load  in  1  instruction is a load
- m_store  in  1  instruction is a store
- m_ldst_type  in  3  000 word, 001 byte unsigned, 010 byte signed, 011 half unsigned, 100 half signed (stores: 001/010 = sb, 011/100 = sh)
- m_addr  in  32  full byte address (ALU result)
- m_wdata  in  32  store source register value
- stall  out  1  freeze PC/F/D/E/M registers
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  write strobe, valid with mem_req
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  32  word address, {m_addr[31:2],2'b00}
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  access complete this cycle
- mem_rdata  in  32  read word, valid when mem_ack and !mem_we
- w_valid  out  1  W-stage valid
- w_addr  out  32  registered full address
- w_ldst_type  out  3  registered type
- w_rdata  out  32  registered raw read word
- w_exc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus error

Behaviour:
- Reset (async, rst_n low): state IDLE; mem_req, mem_we = 0; mem_be = 0; mem_addr, mem_wdata = 0; all w_* = 0; stall = 0.
- Define op = m_valid & (m_load | m_store). m_load and m_store both high: treat as a store.
- Misaligned access:
  - word: m_addr[1:0] != 0
  - half: m_addr[0] != 0
  - bytes are never misaligned
- Store alignment, with lane = m_addr[1:0]:
  - sw: be = 1111, data = m_wdata
  - sh: be = 0011 (lane 0x) or 1100 (lane 1x); data = {2{m_wdata[15:0]}}
  - sb: be = 0001 << lane; data = {4{m_wdata[7:0]}}
- Loads drive be = 1111 and mem_we = 0.
- FSM, two states, IDLE and BUSY:
  - IDLE, op and aligned: stall = 1 (combinational). On the clock edge, register mem_addr/be/we/wdata, set mem_req = 1, go to BUSY.
  - IDLE, op and misaligned: no bus access, stall = 0. The W register loads with w_exc = 01 (load) or 10 (store).
  - IDLE, !op: stall = 0; pass through.
  - BUSY: mem_req and the bus fields are held stable. stall = !mem_ack.
  - BUSY, on mem_ack: clear mem_req, go to IDLE. Because stall = 0 this cycle, the W register captures mem_rdata and the next instruction enters M.
- Stall, cycle by cycle:
  - stall = (IDLE & op & aligned) | (BUSY & !mem_ack).
  - The M-stage inputs are frozen by stall, so a request is never reissued.
  - Minimum latency is 2 cycles per access (issue + ack) when the ack arrives the cycle after the request.
- M/W register, loaded on every edge with stall = 0:
  - w_valid <= m_valid
  - w_addr <= m_addr
  - w_ldst_type <= m_ldst_type
  - w_rdata <= mem_rdata for a completed load, else 0
  - w_exc as above, else 00
- While stall = 1 the W register loads w_valid = 0 (bubble); the other w_* fields hold.
- Boundaries:
  - mem_ack while in IDLE is ignored.
  - mem_ack in the same cycle mem_req rises cannot occur, because req is registered.
  - rst_n low mid-access drops mem_req asynchronously and discards the access.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - an 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without mem_ack;
  - on reaching TIMEOUT_CYCLES, clear mem_req, go to IDLE, stall = 0 that cycle, and load the W register with w_exc = 11, w_rdata = 0.
- Not defined: no counter; BUSY waits for mem_ack indefinitely.

Test Plan:
- lw at 0x1000_0004, ack 1 cycle after req, rdata 0xDEADBEEF -> mem_addr 0x1000_0004, be 1111, stall high 2 cycles, then w_rdata 0xDEADBEEF, w_exc 00.
- sb 0xA5 at 0x0000_0013 -> mem_be 1000, mem_wdata 0xA5A5A5A5, mem_we 1; sh 0x1234 at 0x12 -> be 1100, wdata 0x12341234.
- lh at 0x0000_0003 -> no mem_req, stall 0, w_exc 01; sw at 0x0000_0002 -> w_exc 10.
- Ack delayed 5 cycles -> mem_req and bus fields stable 6 cycles, stall high until the ack cycle, w_valid 0 during the stall, 1 after.
- rst_n low while BUSY -> mem_req 0 immediately, all w_* 0, state IDLE, next access issues normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> mem_req drops after 4 BUSY cycles, w_exc 11, pipeline resumes.
